// File: rtl/vrf_group_reader.sv
// vrf_group_reader: streams a naturally aligned group of 1/2/4/8 vector
// registers out of a register file, one register per beat, with a
// valid/ready handshake on the output side and a one-cycle error pulse
// for an illegal group-size code.
module vrf_group_reader #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_sel,
  input  logic [2:0]        req_vlmul,
  output logic [4:0]        rf_rd_sel,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] base;   // aligned first register of the group
  logic [3:0] count;  // registers in the group: 1, 2, 4 or 8
  logic [2:0] idx;    // position of the beat currently on out_data

  // Clear the low vlmul bits of the requested register so the group is
  // naturally aligned; the group then never wraps past register 31.
  function automatic logic [4:0] align_base(input logic [4:0] sel,
                                            input logic [1:0] vl);
    case (vl)
      2'd0:    return sel;
      2'd1:    return {sel[4:1], 1'b0};
      2'd2:    return {sel[4:2], 2'b00};
      default: return {sel[4:3], 3'b000};
    endcase
  endfunction

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign out_idx   = idx;

  // Read address: the group base while loading, then one register ahead
  // of the beat being presented so the next beat is ready on handshake.
  always_comb begin
    rf_rd_sel = 5'd0;
    case (state)
      LOAD:    rf_rd_sel = base;
      SEND:    rf_rd_sel = base + {2'b00, idx} + 5'd1;
      default: rf_rd_sel = 5'd0;
    endcase
  end

  // Control FSM with registered outputs; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= 5'd0;
      count     <= 4'd0;
      idx       <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_vlmul[2]) begin
              err <= 1'b1;
            end else begin
              base  <= align_base(req_sel, req_vlmul[1:0]);
              count <= 4'd1 << req_vlmul[1:0];
              idx   <= 3'd0;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          out_data  <= rf_rd_data;
          idx       <= 3'd0;
          out_last  <= (count == 4'd1);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              idx      <= idx + 3'd1;
              out_data <= rf_rd_data;
              out_last <= (({1'b0, idx} + 4'd2) == count);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vrf_group_reader.sv
// Scoreboard bench for vrf_group_reader: the driver pushes the expected
// beats of each group (computed from alignment rules on a register-file
// array) and an independent monitor pops and compares on every handshake.
module tb_vrf_group_reader;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_sel;
  logic [2:0]        req_vlmul;
  logic [4:0]        rf_rd_sel;
  logic [DATA_W-1:0] rf_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_idx;
  logic              out_last;
  logic              busy;
  logic              err;

  logic [DATA_W-1:0] rf [32];
  assign rf_rd_data = rf[rf_rd_sel];

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [2:0]        idx;
    logic              last;
    logic [4:0]        addr;
  } beat_t;

  beat_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random

  vrf_group_reader #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_vlmul(req_vlmul),
    .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
    check({tag, "_out_idx"},   64'(out_idx),   64'd0);
    check({tag, "_out_last"},  64'(out_last),  64'd0);
    check({tag, "_err"},       64'(err),       64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_rf_rd_sel"}, 64'(rf_rd_sel), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  // Reference model: a group is the naturally aligned block of 2^vlmul
  // registers containing sel; beats come out in ascending register order.
  task automatic push_group(input logic [4:0] sel, input logic [2:0] vl);
    int cnt;
    int b;
    beat_t e;
    cnt = 1 << vl[1:0];
    b = (int'(sel) / cnt) * cnt;
    for (int i = 0; i < cnt; i++) begin
      e.addr = 5'((b + i) % 32);
      e.data = rf[e.addr];
      e.idx  = 3'(i);
      e.last = (i == cnt - 1);
      q.push_back(e);
    end
  endtask

  // Present a request from a falling edge, hold until accepted; returns
  // just after the accepting rising edge.
  task automatic issue(input logic [4:0] sel, input logic [2:0] vl);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = sel;
    req_vlmul = vl;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL req_accept_timeout: req_ready got 0 expected 1");
      req_valid = 1'b0;
    end else begin
      if (!vl[2]) push_group(sel, vl);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_sel   = 5'($urandom);
      req_vlmul = 3'($urandom);
      if (vl[2]) begin
        @(negedge clk);
        check("err_pulse", 64'(err), 64'd1);
        check("err_no_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("err_cleared", 64'(err), 64'd0);
        check("err_ready_again", 64'(req_ready), 64'd1);
      end
    end
  endtask

  // Wait for the group to drain, throwing random requests at the DUT
  // while it is busy; those must be ignored.
  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (busy) begin
        req_valid = 1'($urandom_range(0, 1));
        req_sel   = 5'($urandom);
        req_vlmul = 3'($urandom);
      end else begin
        req_valid = 1'b0;
        if (q.size() == 0) done = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: pending beats %0d expected 0", q.size());
    end
  endtask

  // Consumer ready pattern, changed away from the sampling edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pop and compare on every output handshake, and check that
  // a stalled beat is held unchanged.
  initial begin
    beat_t e;
    bit hold;
    logic [DATA_W-1:0] h_data;
    logic [2:0] h_idx;
    logic h_last;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_hold", {out_valid, out_data, out_idx, out_last},
                {1'b1, h_data, h_idx, h_last});
          hold = 1'b0;
        end
        if (out_valid) begin
          if (out_ready) begin
            if (q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_beat: got data %0h idx %0d expected no beat", out_data, out_idx);
            end else begin
              e = q.pop_front();
              check("beat", {out_data, out_idx, out_last}, {e.data, e.idx, e.last});
              if (!out_last && q.size() > 0)
                check("rd_sel_next", 64'(rf_rd_sel), 64'(q[0].addr));
            end
          end else begin
            hold   = 1'b1;
            h_data = out_data;
            h_idx  = out_idx;
            h_last = out_last;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;
    req_valid = 1'b0;
    req_sel = 5'd0;
    req_vlmul = 3'd0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("ready_after_release", 64'(req_ready), 64'd1);

    // Single register: latency and read address.
    ready_mode = 0;
    issue(5'd7, 3'b000);
    @(negedge clk);
    check("load_rd_sel", 64'(rf_rd_sel), 64'd7);
    check("load_no_valid", 64'(out_valid), 64'd0);
    check("load_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("first_beat_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("single_done_busy", 64'(busy), 64'd0);
    wait_idle();

    // Eight-register group with patterned contents.
    for (int r = 0; r < 32; r++) rf[r] = 32'(r * 32'h11);
    issue(5'd13, 3'b011);
    wait_idle();

    // Four-register group with alternating stalls.
    ready_mode = 1;
    issue(5'd22, 3'b010);
    wait_idle();

    // Illegal group size.
    ready_mode = 0;
    issue(5'd9, 3'b101);
    wait_idle();

    // Reset in the middle of a burst.
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    issue(5'd24, 3'b011);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'd3) found = 1'b1;
    end
    check("abort_reached_beat3", 64'(found), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_beats", 64'(out_valid), 64'd0);
    issue(5'd3, 3'b001);
    wait_idle();

    // Randomized groups, ready patterns and register contents.
    for (int t = 0; t < 40; t++) begin
      ready_mode = $urandom_range(0, 2);
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      issue(5'($urandom), 3'($urandom_range(0, 5)));
      wait_idle();
    end

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
